// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register for the execute stage.
//
// Holds the Z/N/C flags (bit0=Z, bit1=N, bit2=C) produced by the ALU. It also
// implements SETC/CLRC and evaluates JZ/JN/JC, clearing the tested flag when a
// jump is taken. A shadow stack saves the flags on interrupt entry and
// restores them on RTI.
//
// Build option: define CCR_NEST_EN for a 2-deep LIFO shadow stack, which
// allows one nested interrupt. Without it the stack has a single entry and
// shadow_cnt[1] is tied to 0.
//
// Request semantics: setc, clrc, jz/jn/jc, int_save and rti_restore are
// single-cycle strobes with no ready/acknowledge. They are sampled on the
// rising clk edge only when stall=0. While stall=1 they are ignored and all
// state holds. jmp_taken is a pure combinational decision from the registered
// ccr and is never gated by stall.

module ccr_unit #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] flag_we,
  input  logic              setc,
  input  logic              clrc,
  input  logic              jz,
  input  logic              jn,
  input  logic              jc,
  input  logic              int_save,
  input  logic              rti_restore,
  input  logic [FLAG_W-1:0] mem_flags_in,
  output logic [FLAG_W-1:0] ccr,
  output logic              jmp_taken,
  output logic [1:0]        shadow_cnt,
  output logic              shadow_ovf
);

  localparam int BIT_Z = 0;
  localparam int BIT_N = 1;
  localparam int BIT_C = 2;

  // Per-flag "jump taken on this flag" vector. A set bit also means the flag
  // is consumed at the next edge.
  logic [FLAG_W-1:0] jump_hit;

  // Restore source: the stack top, or the data-stack flags if the stack is empty.
  logic [FLAG_W-1:0] stack_top;
  logic              stack_empty;

  // A save that coincides with an RTI is dropped, so only the pop happens.
  logic              do_push;
  logic              do_pop;

  logic [FLAG_W-1:0] ccr_next;
  logic              ovf_next;

  assign do_push = int_save & ~rti_restore;
  assign do_pop  = rti_restore & ~stack_empty;

  // Jump decision: OR of the per-flag tests (an illegal multi-hot request ORs).
  always_comb begin
    jump_hit        = '0;
    jump_hit[BIT_Z] = jz & ccr[BIT_Z];
    jump_hit[BIT_N] = jn & ccr[BIT_N];
    jump_hit[BIT_C] = jc & ccr[BIT_C];
    jmp_taken       = |jump_hit;
  end

  // Next flag value. Priority from lowest to highest is jump consume, then
  // flag_we, then setc/clrc on C. rti_restore replaces the whole register.
  always_comb begin
    ccr_next = ccr;
    if (rti_restore) begin
      ccr_next = stack_empty ? mem_flags_in : stack_top;
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (flag_we[i]) begin
          ccr_next[i] = alu_flags[i];
        end else if (jump_hit[i]) begin
          ccr_next[i] = 1'b0;
        end
      end
      if (setc) begin
        ccr_next[BIT_C] = 1'b1;
      end else if (clrc) begin
        ccr_next[BIT_C] = 1'b0;
      end
    end
  end

  // Flag register. A stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr <= '0;
    end else if (!stall) begin
      ccr <= ccr_next;
    end
  end

  // Sticky overflow register. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_ovf <= 1'b0;
    end else if (!stall) begin
      shadow_ovf <= ovf_next;
    end
  end

`ifdef CCR_NEST_EN

  // Two-entry LIFO. stk_old holds the outer interrupt's flags. stk_new holds
  // the nested interrupt's flags and is valid only when the count is 2.
  logic [FLAG_W-1:0] stk_old;
  logic [FLAG_W-1:0] stk_new;
  logic [1:0]        cnt_q;
  logic [FLAG_W-1:0] stk_old_next;
  logic [FLAG_W-1:0] stk_new_next;
  logic [1:0]        cnt_next;

  assign stack_empty = (cnt_q == 2'd0);
  assign stack_top   = (cnt_q == 2'd2) ? stk_new : stk_old;
  assign shadow_cnt  = cnt_q;

  // Stack next state. A push at full drops the oldest entry and shifts.
  always_comb begin
    stk_old_next = stk_old;
    stk_new_next = stk_new;
    cnt_next     = cnt_q;
    ovf_next     = shadow_ovf;
    if (do_pop) begin
      cnt_next = cnt_q - 2'd1;
    end else if (do_push) begin
      case (cnt_q)
        2'd0: begin
          stk_old_next = ccr;
          cnt_next     = 2'd1;
        end
        2'd1: begin
          stk_new_next = ccr;
          cnt_next     = 2'd2;
        end
        default: begin
          stk_old_next = stk_new;
          stk_new_next = ccr;
          cnt_next     = 2'd2;
          ovf_next     = 1'b1;
        end
      endcase
    end
  end

  // Stack registers. A stall freezes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_old <= '0;
      stk_new <= '0;
      cnt_q   <= 2'd0;
    end else if (!stall) begin
      stk_old <= stk_old_next;
      stk_new <= stk_new_next;
      cnt_q   <= cnt_next;
    end
  end

`else

  // Single shadow entry with a valid bit. A push while valid overwrites it.
  logic [FLAG_W-1:0] stk_entry;
  logic              stk_vld;
  logic [FLAG_W-1:0] stk_entry_next;
  logic              stk_vld_next;

  assign stack_empty = ~stk_vld;
  assign stack_top   = stk_entry;
  assign shadow_cnt  = {1'b0, stk_vld};

  // Stack next state.
  always_comb begin
    stk_entry_next = stk_entry;
    stk_vld_next   = stk_vld;
    ovf_next       = shadow_ovf;
    if (do_pop) begin
      stk_vld_next = 1'b0;
    end else if (do_push) begin
      stk_entry_next = ccr;
      stk_vld_next   = 1'b1;
      if (stk_vld) begin
        ovf_next = 1'b1;
      end
    end
  end

  // Stack registers. A stall freezes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_entry <= '0;
      stk_vld   <= 1'b0;
    end else if (!stall) begin
      stk_entry <= stk_entry_next;
      stk_vld   <= stk_vld_next;
    end
  end

`endif

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: directed and light random stimulus for ccr_unit.
// A flag/stack model runs alongside the DUT and is compared on every falling
// edge. Hand-computed literal checks pin the model at key points.

module tb_ccr_unit;

`ifdef CCR_NEST_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall;
  logic [2:0] alu_flags;
  logic [2:0] flag_we;
  logic       setc;
  logic       clrc;
  logic       jz;
  logic       jn;
  logic       jc;
  logic       int_save;
  logic       rti_restore;
  logic [2:0] mem_flags_in;
  logic [2:0] ccr;
  logic       jmp_taken;
  logic [1:0] shadow_cnt;
  logic       shadow_ovf;

  int n_pass  = 0;
  int n_total = 0;
  bit run     = 1'b0;

  // Model state: the flags, the shadow stack as a queue (newest at the back),
  // and the sticky overflow flag.
  logic [2:0] m_ccr;
  logic [2:0] exp_q[$];
  logic       m_ovf;

  ccr_unit #(.FLAG_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .alu_flags(alu_flags),
    .flag_we(flag_we), .setc(setc), .clrc(clrc), .jz(jz), .jn(jn), .jc(jc),
    .int_save(int_save), .rti_restore(rti_restore),
    .mem_flags_in(mem_flags_in), .ccr(ccr), .jmp_taken(jmp_taken),
    .shadow_cnt(shadow_cnt), .shadow_ovf(shadow_ovf)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_jmp();
    return (jz && m_ccr[0]) || (jn && m_ccr[1]) || (jc && m_ccr[2]);
  endfunction

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (run) begin
      check("ccr", 4'(ccr), 4'(m_ccr));
      check("jmp_taken", 4'(jmp_taken), 4'(model_jmp()));
      check("shadow_cnt", 4'(shadow_cnt), 4'(exp_q.size()));
      check("shadow_ovf", 4'(shadow_ovf), 4'(m_ovf));
    end
  end

  // Model of one clock edge, written from the flag rules.
  task automatic model_step();
    logic [2:0] nxt;
    if (stall) return;
    nxt = m_ccr;
    if (rti_restore) begin
      if (exp_q.size() > 0) nxt = exp_q.pop_back();
      else nxt = mem_flags_in;
    end else begin
      if (int_save) begin
        exp_q.push_back(m_ccr);
        if (exp_q.size() > DEPTH) begin
          void'(exp_q.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (jz && m_ccr[0]) nxt[0] = 1'b0;
      if (jn && m_ccr[1]) nxt[1] = 1'b0;
      if (jc && m_ccr[2]) nxt[2] = 1'b0;
      for (int i = 0; i < 3; i++) if (flag_we[i]) nxt[i] = alu_flags[i];
      if (clrc) nxt[2] = 1'b0;
      if (setc) nxt[2] = 1'b1;
    end
    m_ccr = nxt;
  endtask

  task automatic clear_inputs();
    stall = 0; alu_flags = 0; flag_we = 0; setc = 0; clrc = 0;
    jz = 0; jn = 0; jc = 0; int_save = 0; rti_restore = 0; mem_flags_in = 0;
  endtask

  task automatic model_reset();
    m_ccr = 3'b000;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: the compare runs at negedge, the model advances, the clock
  // edges, and the caller resumes #1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_ccr(input logic [2:0] v);
    clear_inputs();
    flag_we = 3'b111;
    alu_flags = v;
    tick();
    clear_inputs();
  endtask

  task automatic save();
    clear_inputs();
    int_save = 1;
    tick();
    clear_inputs();
  endtask

  task automatic restore(input logic [2:0] mem);
    clear_inputs();
    rti_restore = 1;
    mem_flags_in = mem;
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    run = 1'b1;

    // Reset, then a full flag write.
    do_reset();
    check("rst_ccr", 4'(ccr), 4'h0);
    check("rst_cnt", 4'(shadow_cnt), 4'h0);
    write_ccr(3'b101);
    check("we_ccr", 4'(ccr), 4'h5);

    // JZ consume, then a JZ that is not taken.
    write_ccr(3'b001);
    jz = 1; #1;
    check("jz_taken", 4'(jmp_taken), 4'h1);
    tick();
    check("jz_consumed", 4'(ccr), 4'h0);
    #1;
    check("jz_not_taken", 4'(jmp_taken), 4'h0);
    tick();
    check("jz_hold", 4'(ccr), 4'h0);
    clear_inputs();

    // setc overrides flag_we[2]; setc beats clrc; clrc alone clears.
    flag_we = 3'b100; alu_flags = 3'b000; setc = 1;
    tick();
    check("setc_over_we", 4'(ccr), 4'h4);
    clear_inputs(); setc = 1; clrc = 1;
    tick();
    check("setc_over_clrc", 4'(ccr), 4'h4);
    clear_inputs(); clrc = 1;
    tick();
    check("clrc", 4'(ccr), 4'h0);

    // Stall freezes state while jmp_taken stays live.
    write_ccr(3'b011);
    stall = 1; flag_we = 3'b111; alu_flags = 3'b000; jn = 1; #1;
    check("stall_jmp", 4'(jmp_taken), 4'h1);
    tick();
    check("stall_hold", 4'(ccr), 4'h3);
    clear_inputs(); jn = 1;
    tick();
    check("jn_consumed", 4'(ccr), 4'h1);
    clear_inputs();

    // Interrupt round trip, with a same-cycle flag write.
    write_ccr(3'b110);
    int_save = 1; flag_we = 3'b111; alu_flags = 3'b001;
    tick();
    check("save_ccr", 4'(ccr), 4'h1);
    check("save_cnt", 4'(shadow_cnt), 4'h1);
    restore(3'b000);
    check("rti_ccr", 4'(ccr), 4'h6);
    check("rti_cnt", 4'(shadow_cnt), 4'h0);
    restore(3'b011);
    check("rti_empty_mem", 4'(ccr), 4'h3);
    check("rti_empty_cnt", 4'(shadow_cnt), 4'h0);

    // A save together with a restore only pops.
    save();
    write_ccr(3'b101);
    int_save = 1; rti_restore = 1; mem_flags_in = 3'b111;
    tick();
    clear_inputs();
    check("save_rti_ccr", 4'(ccr), 4'h3);
    check("save_rti_cnt", 4'(shadow_cnt), 4'h0);

    // Nesting and overflow.
    do_reset();
`ifdef CCR_NEST_EN
    write_ccr(3'b001); save();
    write_ccr(3'b010); save();
    write_ccr(3'b100); save();
    check("nest_cnt", 4'(shadow_cnt), 4'h2);
    check("nest_ovf", 4'(shadow_ovf), 4'h1);
    write_ccr(3'b000);
    restore(3'b111);
    check("nest_pop1", 4'(ccr), 4'h4);
    restore(3'b111);
    check("nest_pop2", 4'(ccr), 4'h2);
    check("nest_cnt0", 4'(shadow_cnt), 4'h0);
`else
    write_ccr(3'b001); save();
    write_ccr(3'b010); save();
    check("ovf_cnt", 4'(shadow_cnt), 4'h1);
    check("ovf_set", 4'(shadow_ovf), 4'h1);
    write_ccr(3'b000);
    restore(3'b111);
    check("ovf_pop", 4'(ccr), 4'h2);
    check("ovf_sticky", 4'(shadow_ovf), 4'h1);
`endif

    // An async reset in the middle of an interrupt sequence acts at once.
    write_ccr(3'b111); save();
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_ccr", 4'(ccr), 4'h0);
    check("arst_cnt", 4'(shadow_cnt), 4'h0);
    check("arst_ovf", 4'(shadow_ovf), 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Short random run checked by the model.
    for (int k = 0; k < 60; k++) begin
      int j;
      clear_inputs();
      stall = ($urandom_range(0, 7) == 0);
      flag_we = 3'($urandom_range(0, 7));
      alu_flags = 3'($urandom_range(0, 7));
      setc = ($urandom_range(0, 5) == 0);
      clrc = ($urandom_range(0, 5) == 0);
      j = $urandom_range(0, 5);
      jz = (j == 0); jn = (j == 1); jc = (j == 2);
      int_save = ($urandom_range(0, 3) == 0);
      rti_restore = ($urandom_range(0, 4) == 0);
      mem_flags_in = 3'($urandom_range(0, 7));
      tick();
    end
    clear_inputs();
    @(negedge clk);
    #1;
    run = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
